fmac_sched_driver: RTL and testbench



---
 rtl/fmac_sched_pkg.sv | 26 ++
 rtl/fmac_sched_driver_onehot_seq.sv | 40 ++++
 rtl/fmac_sched_driver.sv | 142 ++++++++++++++
 tb/tb_fmac_sched_driver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmac_sched_pkg.sv
// Shared constants and types for the fmac schedule driver.
// Float format is FloPoCo style: 2 exception bits, sign, exponent, fraction.
package fmac_sched_pkg;

    localparam int unsigned FP_WE = 4;
    localparam int unsigned FP_WF = 4;
    localparam int unsigned FP_W  = 2 + 1 + FP_WE + FP_WF;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } fsm_state_e;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    // Exception field of a FloPoCo word sits in the two MSBs.
    function automatic logic [1:0] exc_field(input logic [FP_W-1:0] x);
        return x[FP_W-1 -: 2];
    endfunction

endpackage

// File: rtl/fmac_sched_driver_onehot_seq.sv
// One-hot shift register: load sets bit0, advance shifts toward the MSB,
// and shifting past the last bit leaves the vector all-zero.
module onehot_seq #(
    parameter int unsigned N = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         adv_i,
    input  logic         clr_i,
    output logic [N-1:0] q_o,
    output logic         last_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = N'(1);
        end else if (adv_i) begin
            q_d = q_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign last_o = q_q[N-1];

endmodule

// File: rtl/fmac_sched_driver.sv
// Issue-side controller: gathers operands, steps the one-hot datapath schedule,
// returns the captured result. FMAC_SCHED_CYCLE_COUNT_EN adds a cycle_count port.
module fmac_sched_driver
    import fmac_sched_pkg::*;
#(
    parameter int unsigned NUM_ARGS   = 8,
    parameter int unsigned NUM_STATES = 15,
    parameter int unsigned W          = FP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_ARGS*W-1:0] args,
    output logic [NUM_STATES-1:0] sched_state,
    output logic                  sched_ce,
    input  logic                  stall,
    input  logic [W-1:0]          result_in,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);

    localparam int unsigned IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

    fsm_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_ARGS*W-1:0] args_q, args_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  seq_load, seq_adv, seq_last;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
    logic [31:0]           cc_q, cc_d;
`endif

    onehot_seq #(.N(NUM_STATES)) u_seq (
        .clk    (clk),
        .reset  (reset),
        .load_i (seq_load),
        .adv_i  (seq_adv),
        .clr_i  (1'b0),
        .q_o    (sched_state),
        .last_o (seq_last)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        args_d      = args_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        seq_load    = 1'b0;
        seq_adv     = 1'b0;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
        cc_d        = cc_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    args_d[idx_q*W +: W] = in_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        state_d  = ST_RUN;
                        seq_load = 1'b1;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
                        cc_d     = '0;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    seq_adv = 1'b1;
                    if (seq_last) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (!stall) begin
                    out_data_d  = result_in;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
        // Stall cycles count too; the counter saturates rather than wrapping.
        if ((state_q == ST_RUN || state_q == ST_CAPTURE) && (cc_q != '1)) begin
            cc_d = cc_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            args_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
            cc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            args_q      <= args_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
            cc_q        <= cc_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign sched_ce  = ((state_q == ST_RUN) || (state_q == ST_CAPTURE)) && !stall;
    assign args      = args_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
    assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_fmac_sched_driver.sv
// Directed bench for fmac_sched_driver with an operation-level reference model
// and an emulated datapath that presents the final sum only after the last state.
module tb_fmac_sched_driver;

    localparam int unsigned NA = 8;
    localparam int unsigned NS = 15;
    localparam int unsigned W  = 11;
    localparam logic [W-1:0] R100 = 11'b01011011001;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NA*W-1:0]   args;
    logic [NS-1:0]     sched_state;
    logic              sched_ce;
    logic              stall = 1'b0;
    logic [W-1:0]      result_in = '0;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
    logic [31:0]       cycle_count;
`endif

    fmac_sched_driver #(.NUM_ARGS(NA), .NUM_STATES(NS), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .args        (args),
        .sched_state (sched_state),
        .sched_ce    (sched_ce),
        .stall       (stall),
        .result_in   (result_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Emulated datapath: garbage while the schedule runs, final value after the last state.
    logic [W-1:0] res_tab [0:15];
    int op_num = 0;
    always @(posedge clk) begin
        if (sched_ce && sched_state[NS-1]) begin
            result_in <= res_tab[op_num];
            op_num    <= op_num + 1;
        end else if (sched_ce && (|sched_state)) begin
            result_in <= W'(cyc * 13 + 5);
        end
    end

    // Reference model: phase 0 = collecting, 1..NS = schedule step, NS+1 = capture, NS+2 = result held.
    int            m_phase = 0;
    int            m_idx = 0;
    logic [NA*W-1:0] m_args = '0;
    logic [W-1:0]  m_out_data = '0;
    logic          m_out_valid = 1'b0;
    logic [31:0]   m_cc = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase <= 0; m_idx <= 0; m_args <= '0;
            m_out_data <= '0; m_out_valid <= 1'b0; m_cc <= '0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_args[m_idx*W +: W] <= in_data;
                if (m_idx == NA - 1) begin
                    m_idx <= 0; m_phase <= 1; m_cc <= '0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end else if (m_phase <= NS + 1) begin
            if (m_cc != 32'hFFFF_FFFF) m_cc <= m_cc + 32'd1;
            if (!stall) begin
                if (m_phase == NS + 1) begin
                    m_out_data <= result_in;
                    m_out_valid <= 1'b1;
                end
                m_phase <= m_phase + 1;
            end
        end else if (out_ready) begin
            m_out_valid <= 1'b0;
            m_phase <= 0;
        end
    end

    function automatic logic [NS-1:0] exp_sched(input int ph);
        logic [NS-1:0] one;
        one = NS'(1);
        if (ph >= 1 && ph <= NS) return one << (ph - 1);
        return '0;
    endfunction

    // Every-cycle comparison against the model.
    logic [W-1:0] got_q [$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 128'(in_ready), 128'(m_phase == 0));
            chk("sched_state", 128'(sched_state), 128'(exp_sched(m_phase)));
            chk("sched_ce", 128'(sched_ce), 128'((m_phase >= 1) && (m_phase <= NS + 1) && !stall));
            chk("args", 128'(args), 128'(m_args));
            chk("out_valid", 128'(out_valid), 128'(m_out_valid));
            chk("out_data", 128'(out_data), 128'(m_out_data));
`ifdef FMAC_SCHED_CYCLE_COUNT_EN
            chk("cycle_count", 128'(cycle_count), 128'(m_cc));
`endif
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    logic [W-1:0] op_words [0:NA-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        bit acc;
        bit ok;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic feed_op(input bit gapped, output int k);
        for (int i = 0; i < NA; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                tick();
            end
            push_word(op_words[i]);
        end
        in_valid = 1'b0;
        k = cyc;
    endtask

    task automatic run_op(input string name, input bit gapped, input int stall_len,
                          input int bp_len, input logic [W-1:0] exp_res);
        int k;
        int rise;
        feed_op(gapped, k);
        chk({name, "_state01"}, 128'(sched_state), 128'(1));
        if (stall_len > 0) begin
            for (int i = 0; i < 4; i++) tick();
            chk({name, "_state05"}, 128'(sched_state), 128'(16'h0010));
            stall = 1'b1;
            for (int s = 0; s < stall_len; s++) begin
                @(negedge clk);
                chk({name, "_stall_hold"}, 128'(sched_state), 128'(16'h0010));
                chk({name, "_stall_ce"}, 128'(sched_ce), 128'(0));
                tick();
            end
            stall = 1'b0;
        end
        rise = -1;
        for (int t = 0; t < 200; t++) begin
            if (out_valid) begin
                rise = cyc;
                break;
            end
            tick();
        end
        chk({name, "_latency"}, 128'(rise - k), 128'(NS + 1 + stall_len));
        chk({name, "_result"}, 128'(out_data), 128'(exp_res));
        for (int b = 0; b < bp_len; b++) begin
            tick();
            chk({name, "_bp_valid"}, 128'(out_valid), 128'(1));
            chk({name, "_bp_data"}, 128'(out_data), 128'(exp_res));
            chk({name, "_bp_inready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_post_valid"}, 128'(out_valid), 128'(0));
        chk({name, "_post_inready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int k;
        logic [W-1:0] b2b [0:2*NA-1];

        for (int i = 0; i < 16; i++) res_tab[i] = R100;
        res_tab[5] = 11'b01001110000;
        res_tab[6] = 11'b01100000101;
        op_words[0] = 11'b01001110000; op_words[1] = 11'b01010000000;
        op_words[2] = 11'b01010001000; op_words[3] = 11'b01010010000;
        op_words[4] = 11'b01010010100; op_words[5] = 11'b01010011000;
        op_words[6] = 11'b01010011100; op_words[7] = 11'b01010100000;

        reset = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_sched", 128'(sched_state), 128'(0));
        chk("rst_args", 128'(args), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));

        run_op("basic", 1'b0, 0, 0, R100);
        chk("basic_args", 128'(args),
            128'({op_words[7], op_words[6], op_words[5], op_words[4],
                  op_words[3], op_words[2], op_words[1], op_words[0]}));
        run_op("stall", 1'b0, 3, 0, R100);
        run_op("backpressure", 1'b0, 0, 10, R100);

        // Abort an operation while state07 is active.
        feed_op(1'b0, k);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid_state07", 128'(sched_state), 128'(16'h0040));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_mid_sched", 128'(sched_state), 128'(0));
        chk("rst_mid_args", 128'(args), 128'(0));
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_inready", 128'(in_ready), 128'(1));
        run_op("after_reset", 1'b0, 0, 0, R100);

        run_op("gapped", 1'b1, 0, 0, R100);

        // Two operations streamed continuously with the sink always ready.
        for (int i = 0; i < 2 * NA; i++) b2b[i] = W'(11'h155 + i * 37);
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * NA; i++) push_word(b2b[i]);
        in_valid = 1'b0;
        for (int t = 0; t < 200 && got_q.size() < 2; t++) tick();
        out_ready = 1'b0;
        chk("b2b_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() >= 2) begin
            chk("b2b_first", 128'(got_q[0]), 128'(11'b01001110000));
            chk("b2b_second", 128'(got_q[1]), 128'(11'b01100000101));
        end
        chk("b2b_args", 128'(args[W-1:0]), 128'(b2b[NA]));
        tick(); tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
